// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and an optional 2-entry skid buffer.
// It carries instruction, PC and exception cause, and supports flush, an occupancy output and a stall counter.
module pipe_stage_reg #(
  parameter int          DATA_W      = 32,
  parameter int          PC_W        = 32,
  parameter int          EXC_W       = 2,
  parameter logic [31:0] RESET_PC    = 32'h80000000,
  parameter bit          SKID_EN     = 1'b1,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_instr,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [EXC_W-1:0]       in_exc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic [EXC_W-1:0]       out_exc,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  function automatic logic [DATA_W-1:0] nop_on_exc(input logic [DATA_W-1:0] instr,
                                                   input logic [EXC_W-1:0]  exc);
    return (exc != '0) ? '0 : instr;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + STALL_CNT_W'(1);
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_W-1:0]      r_main_instr;
  logic [PC_W-1:0]        r_main_pc;
  logic [EXC_W-1:0]       r_main_exc;
  logic [DATA_W-1:0]      r_skid_instr;
  logic [PC_W-1:0]        r_skid_pc;
  logic [EXC_W-1:0]       r_skid_exc;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_acc;
  logic                   w_cons;
  logic                   w_ld_main_in;
  logic                   w_ld_main_skid;
  logic                   w_ld_skid;
  logic                   w_clr_main;
  logic [DATA_W-1:0]      w_in_instr;

  assign out_valid  = (r_state != S_EMPTY);
  assign w_acc      = in_valid && in_ready;
  assign w_cons     = out_valid && out_ready;
  assign w_in_instr = nop_on_exc(in_instr, in_exc);

  generate
    if (SKID_EN) begin : g_skid
      // in_ready is a pure flop: it looks one state ahead so it never admits into a full stage
      logic r_in_ready;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_in_ready <= 1'b1;
        else        r_in_ready <= (w_state_nxt != S_FULL);
      end
      assign in_ready = r_in_ready;
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr_main     = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_clr_main  = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            w_state_nxt  = S_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_acc && w_cons) begin
            w_ld_main_in = 1'b1;
          end else if (w_cons) begin
            w_state_nxt = S_EMPTY;
          end else if (w_acc) begin
            w_state_nxt = S_FULL;
            w_ld_skid   = 1'b1;
          end
        end
        S_FULL: begin
          if (w_cons) begin
            w_state_nxt    = S_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // main entry drives out_*; it keeps its last value when the stage drains
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_instr <= '0;
      r_main_pc    <= RST_PC;
      r_main_exc   <= '0;
    end else if (w_clr_main) begin
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_main_exc   <= '0;
    end else if (w_ld_main_in) begin
      r_main_instr <= w_in_instr;
      r_main_pc    <= in_pc;
      r_main_exc   <= in_exc;
    end else if (w_ld_main_skid) begin
      r_main_instr <= r_skid_instr;
      r_main_pc    <= r_skid_pc;
      r_main_exc   <= r_skid_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_skid) begin
      r_skid_instr <= w_in_instr;
      r_skid_pc    <= in_pc;
      r_skid_exc   <= in_exc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       r_stall_cnt <= '0;
    else if (out_valid && !out_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign out_instr = r_main_instr;
  assign out_pc    = r_main_pc;
  assign out_exc   = r_main_exc;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a no-skid instance share stimulus and are each
// compared every cycle against a queue-style reference model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  exc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [1:0]  in_exc;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_instr, a_out_pc, b_out_instr, b_out_pc;
  logic [1:0]  a_out_exc, a_occ, b_out_exc, b_occ;
  logic [3:0]  a_stall, b_stall;

  int n_chk  = 0;
  int n_fail = 0;

  ent_t mq[2][2];
  ent_t shown[2];
  int   mcnt[2];
  int   mstall[2];

  pipe_stage_reg #(.SKID_EN(1'b1), .STALL_CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
    .out_pc(a_out_pc), .out_exc(a_out_exc), .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.SKID_EN(1'b0), .STALL_CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
    .out_pc(b_out_pc), .out_exc(b_out_exc), .occupancy(b_occ), .stall_cnt(b_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int k);
    if (k == 0) return (mcnt[0] < 2);
    return (mcnt[1] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k]   = 0;
      mstall[k] = 0;
      shown[k]  = '{instr: 32'h0, pc: 32'h80000000, exc: 2'b00};
    end
  endtask

  task automatic model_step();
    bit rdy[2];
    for (int k = 0; k < 2; k++) rdy[k] = m_ready(k);
    for (int k = 0; k < 2; k++) begin
      ent_t e;
      if (mcnt[k] > 0 && !out_ready && mstall[k] < 15) mstall[k]++;
      if (flush) begin
        mcnt[k]  = 0;
        shown[k] = '0;
      end else begin
        if (mcnt[k] > 0 && out_ready) begin
          mq[k][0] = mq[k][1];
          mcnt[k]--;
        end
        if (in_valid && rdy[k]) begin
          e.instr = (in_exc != 2'b00) ? 32'h0 : in_instr;
          e.pc    = in_pc;
          e.exc   = in_exc;
          mq[k][mcnt[k]] = e;
          mcnt[k]++;
        end
        if (mcnt[k] > 0) shown[k] = mq[k][0];
      end
    end
  endtask

  task automatic check_outputs();
    chk("a_valid", {31'b0, a_out_valid}, {31'b0, mcnt[0] > 0});
    chk("a_instr", a_out_instr, shown[0].instr);
    chk("a_pc",    a_out_pc,    shown[0].pc);
    chk("a_exc",   {30'b0, a_out_exc}, {30'b0, shown[0].exc});
    chk("a_occ",   {30'b0, a_occ}, mcnt[0]);
    chk("a_stall", {28'b0, a_stall}, mstall[0]);
    chk("b_valid", {31'b0, b_out_valid}, {31'b0, mcnt[1] > 0});
    chk("b_instr", b_out_instr, shown[1].instr);
    chk("b_pc",    b_out_pc,    shown[1].pc);
    chk("b_exc",   {30'b0, b_out_exc}, {30'b0, shown[1].exc});
    chk("b_occ",   {30'b0, b_occ}, mcnt[1]);
    chk("b_stall", {28'b0, b_stall}, mstall[1]);
  endtask

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [1:0] ex, input bit fl, input bit ordy);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    in_exc    = ex;
    flush     = fl;
    out_ready = ordy;
    #1;
    chk("a_in_ready", {31'b0, a_in_ready}, {31'b0, m_ready(0)});
    chk("b_in_ready", {31'b0, b_in_ready}, {31'b0, m_ready(1)});
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_exc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_instr", a_out_instr, 32'h0);
    chk("rst_pc",    a_out_pc, 32'h80000000);
    chk("rst_exc",   {30'b0, a_out_exc}, 32'd0);
    chk("rst_occ",   {30'b0, a_occ}, 32'd0);
    chk("rst_stall", {28'b0, a_stall}, 32'd0);
    chk("rst_ready", {31'b0, a_in_ready}, 32'd1);
    reset = 1'b1;
    check_outputs();

    // single entry, one-cycle latency
    cycle(1'b1, 32'h00430820, 32'h80000000, 2'b00, 1'b0, 1'b1);
    chk("single_valid", {31'b0, a_out_valid}, 32'd1);
    chk("single_instr", a_out_instr, 32'h00430820);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("single_occ", {30'b0, a_occ}, 32'd0);

    // backpressure fill and ordered drain
    cycle(1'b1, 32'hA0, 32'h100, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 32'hA4, 32'h104, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 32'hA8, 32'h108, 2'b00, 1'b0, 1'b0);
    chk("fill_occ",   {30'b0, a_occ}, 32'd2);
    chk("fill_ready", {31'b0, a_in_ready}, 32'd0);
    chk("fill_pc",    a_out_pc, 32'h100);
    cycle(1'b1, 32'hA8, 32'h108, 2'b00, 1'b0, 1'b1);
    chk("drain_pc1", a_out_pc, 32'h104);
    cycle(1'b1, 32'hA8, 32'h108, 2'b00, 1'b0, 1'b1);
    chk("drain_pc2", a_out_pc, 32'h108);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);

    // exception converts to NOP but keeps pc and cause
    cycle(1'b1, 32'hFFFFFFFF, 32'h200, 2'b01, 1'b0, 1'b0);
    chk("exc_instr", a_out_instr, 32'h0);
    chk("exc_pc",    a_out_pc, 32'h200);
    chk("exc_exc",   {30'b0, a_out_exc}, 32'd1);
    chk("exc_valid", {31'b0, a_out_valid}, 32'd1);

    // flush while full, with in_valid and out_ready asserted
    cycle(1'b1, 32'h55, 32'h204, 2'b00, 1'b0, 1'b0);
    chk("pre_flush_occ", {30'b0, a_occ}, 32'd2);
    cycle(1'b1, 32'h66, 32'h300, 2'b00, 1'b1, 1'b1);
    chk("flush_valid", {31'b0, a_out_valid}, 32'd0);
    chk("flush_pc",    a_out_pc, 32'h0);
    chk("flush_occ",   {30'b0, a_occ}, 32'd0);
    chk("flush_ready", {31'b0, a_in_ready}, 32'd1);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("flush_pc_after", a_out_pc, 32'h0);

    // stall counter saturation, then asynchronous reset mid-stall
    cycle(1'b1, 32'h11111111, 32'h400, 2'b00, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("stall_sat", {28'b0, a_stall}, 32'd15);
    #2 reset = 1'b0;
    #1;
    chk("async_stall", {28'b0, a_stall}, 32'd0);
    chk("async_pc",    a_out_pc, 32'h80000000);
    chk("async_valid", {31'b0, a_out_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_outputs();

    // no-skid throughput
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'hC000 + i, 32'h500 + 4 * i, 2'b00, 1'b0, 1'b1);
      chk("thru_valid", {31'b0, b_out_valid}, 32'd1);
      chk("thru_ready", {31'b0, b_in_ready}, 32'd1);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit          iv, fl, ordy;
      logic [1:0]  ex;
      iv   = ($urandom_range(0, 9) < 7);
      ex   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fl   = ($urandom_range(0, 19) == 0);
      ordy = 1'($urandom_range(0, 1));
      cycle(iv, $urandom, $urandom, ex, fl, ordy);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
